uart_baudgen: RTL and testbench
===============================

# uart_baudgen

Parametrised UART baud/oversample timing generator; successor to the fixed 16x clock generator. It adds a programmable oversampling ratio, an optional fractional divider, an explicit enable and a 3-sample RX vote window. It sits between the UART register interface, which supplies the divider configuration, and the TX/RX shift engines, which consume its single-cycle pulses. TX and RX timing are independent so RX can resynchronise on each start-bit edge without disturbing TX.

## Interface
- DIV_BITS, 16, width of integer divider
- FRAC_BITS, 4, width of fractional divider/accumulator
- OVS_BITS, 4, width of oversample-count field (max ratio 2^OVS_BITS)
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  generator enable; low clears all counters
- i_div_int  in  DIV_BITS  integer divider D; oversample tick period = D+1 clocks
- i_div_frac  in  FRAC_BITS  fractional divider F; adds F/2^FRAC_BITS clocks average
- i_ovs  in  OVS_BITS  oversample ratio minus 1 (N); legal N ≥ 3
- i_rxsync  in  1  restart RX bit timing (start-bit edge from RX engine)
- o_txtick  out  1  TX oversample tick
- o_txpulse  out  1  TX bit boundary, once per N+1 TX ticks
- o_rxtick  out  1  RX oversample tick
- o_rxpulse  out  1  RX mid-bit sample strobe
- o_rxwin  out  1  RX vote window: high on ticks M-1, M, M+1

## Operation
- All outputs are registered single-cycle pulses. Reset value of every output and counter is 0.
- Config shadow registers for D, F and N load on every clock while i_en=0. They are frozen while i_en=1, so config changes during operation are ignored.
- i_en=0: prescalers, tick counters and accumulators are held at 0; outputs are 0 from the next edge.
- TX prescaler, on each enabled edge:
  - if cnt == Deff: cnt←0 and o_txtick←1
  - otherwise cnt←cnt+1
  - Deff = D, or D+1 when the stretch flag is set.
- TX tick index k (1-based) increments per tick and wraps after N+1. o_txpulse asserts together with the tick where k = N+1.
- RX prescaler and index work identically, with independent state.
  - M = (N+1)>>1.
  - o_rxpulse asserts with the RX tick where k = M.
  - o_rxwin asserts with RX ticks k ∈ {M-1, M, M+1}.
- i_rxsync=1 on an enabled edge clears the RX prescaler, index and accumulator. No RX tick or pulse is produced that edge; counting resumes on the next edge.
- Simultaneous i_rxsync and RX terminal count: sync wins and the tick is suppressed. TX is unaffected.
- Fractional divider, per channel, on each tick: {c,acc} ← acc + F. A carry sets the stretch flag for the next period only.
- D=0 is legal: the tick fires every clock (every other clock on a stretched period).
- N<3 is out of range: the window is undefined and o_rxpulse still follows k = M.

## Timing
- From the first enabled edge, the first o_txtick is visible after edge D+1 (F=0). The first o_txpulse is visible after edge (N+1)(D+1).
- After an i_rxsync edge E with F=0:
  - o_rxpulse follows edge E + M(D+1).
  - o_rxwin follows edges E + (M-1)(D+1), E + M(D+1) and E + (M+1)(D+1).
- Reset asserted mid-operation clears everything immediately. After release, behaviour equals a fresh enable.

## Configuration
- UART_BAUDGEN_FRAC_EN defined: accumulators and stretch logic are present; period behaves as described above.
- Undefined: no accumulators; every period is exactly D+1; i_div_frac is ignored, but the port remains.

## Structure
- Shared package uart_pkg holds:
  - default DIV_BITS, FRAC_BITS, OVS_BITS
  - the mid-index function M = (N+1)>>1
- Sub-module uart_baud_prescaler contains the counter, fractional accumulator, stretch flag, tick index and synchronous clear input. It is instantiated twice: TX with clear tied to 0, RX with clear = i_rxsync.

## Test plan
- D=3, N=15, F=0, i_en↑ → o_txtick every 4 clocks; first o_txpulse after edge 64, then every 64.
- FRAC_EN, D=2, F=8, FRAC_BITS=4 → tick periods 3,3,4,3,4,…; 16th o_txtick after edge 55.
- D=3, N=15, i_rxsync at edge E → o_rxwin after E+28, E+32, E+36; o_rxpulse after E+32, repeating every 64.
- i_rxsync on an RX terminal-count edge → no o_rxtick that edge; next o_rxtick after 4 more edges; TX cadence unchanged.
- D=0, N=3 → o_txtick every clock, o_txpulse every 4, o_rxpulse at 2 clocks after sync.
- i_en↓ and i_rst mid-bit → all outputs 0; change D while enabled → no effect; re-enable → restart from the first-tick timing.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART baud/oversample timing generator:
//   - default widths of the integer divider, fractional divider and
//     oversample-count fields
//   - mid_idx(): mid-bit oversample index M = (N+1)>>1, where N is the
//     oversample ratio minus one
// Optional feature macro used by the importing files: UART_BAUDGEN_FRAC_EN
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DIV_BITS  = 16;
   localparam int UART_FRAC_BITS = 4;
   localparam int UART_OVS_BITS  = 4;

   // Tick index (1-based) that lands in the middle of a bit.
   function automatic int unsigned mid_idx(input int unsigned ovs);
      return (ovs + 1) >> 1;
   endfunction

endpackage

// File: rtl/uart_baud_prescaler.sv
// -----------------------------------------------------------------------------
// uart_baud_prescaler
// One oversample timing channel: clock prescaler, optional fractional
// accumulator with stretch flag, and the 1-based tick index within a bit.
// Optional feature macro: UART_BAUDGEN_FRAC_EN (fractional accumulator and
// stretch logic; when undefined every period is exactly div_i+1 clocks).
//
// Ports
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   en_i    enable; low holds all state at 0
//   clr_i   synchronous restart of this channel (suppresses that edge's tick)
//   div_i   integer divider D (period D+1 clocks)
//   frac_i  fractional divider F
//   ovs_i   oversample ratio minus one (N)
//   tc_o    terminal count: a tick is emitted on the coming edge
//   k_o     1-based index of that tick within the bit (1..N+1)
// -----------------------------------------------------------------------------
module uart_baud_prescaler
   import uart_pkg::*;
#(
   parameter int DIV_BITS  = UART_DIV_BITS,
   parameter int FRAC_BITS = UART_FRAC_BITS,
   parameter int OVS_BITS  = UART_OVS_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic [DIV_BITS-1:0]  div_i,
   input  logic [FRAC_BITS-1:0] frac_i,
   input  logic [OVS_BITS-1:0]  ovs_i,
   output logic                 tc_o,
   output logic [OVS_BITS:0]    k_o
);

   // One extra bit so a stretched period (D+1) fits even at D = max.
   logic [DIV_BITS:0]   cnt_q, cnt_d;
   logic [OVS_BITS-1:0] idx_q, idx_d;
   logic [DIV_BITS:0]   deff;
   logic                stretch;
   logic                hit;

   assign deff = {1'b0, div_i} + (DIV_BITS+1)'(stretch);
   assign hit  = (cnt_q == deff);
   assign tc_o = en_i & ~clr_i & hit;
   assign k_o  = {1'b0, idx_q} + (OVS_BITS+1)'(1);

   always_comb begin
      cnt_d = cnt_q + (DIV_BITS+1)'(1);
      idx_d = idx_q;
      if (!en_i || clr_i) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (hit) begin
         cnt_d = '0;
         idx_d = (idx_q == ovs_i) ? '0 : idx_q + OVS_BITS'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

`ifdef UART_BAUDGEN_FRAC_EN
   logic [FRAC_BITS-1:0] acc_q, acc_d;
   logic                 str_q, str_d;

   // Carry out of acc+F stretches only the period that follows this tick.
   always_comb begin
      acc_d = acc_q;
      str_d = str_q;
      if (!en_i || clr_i) begin
         acc_d = '0;
         str_d = 1'b0;
      end else if (hit) begin
         {str_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_q <= '0;
         str_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         str_q <= str_d;
      end
   end

   assign stretch = str_q;
`else
   logic unused_frac;

   assign unused_frac = ^frac_i;
   assign stretch     = 1'b0;
`endif

endmodule

// File: rtl/uart_baudgen.sv
// -----------------------------------------------------------------------------
// uart_baudgen
// UART baud/oversample timing generator with independent TX and RX channels.
// Divider configuration is shadowed while disabled and frozen while enabled.
// Optional feature macro: UART_BAUDGEN_FRAC_EN (fractional divider).
//
// Ports
//   i_clk       clock
//   i_rst       asynchronous active-high reset
//   i_en        generator enable; low clears all counters
//   i_div_int   integer divider D (tick period D+1 clocks)
//   i_div_frac  fractional divider F (ignored without the fractional build)
//   i_ovs       oversample ratio minus one (N), legal N >= 3
//   i_rxsync    restart RX bit timing on a start-bit edge
//   o_txtick    TX oversample tick
//   o_txpulse   TX bit boundary (tick index N+1)
//   o_rxtick    RX oversample tick
//   o_rxpulse   RX mid-bit strobe (tick index M)
//   o_rxwin     RX vote window (tick indices M-1, M, M+1)
// -----------------------------------------------------------------------------
module uart_baudgen
   import uart_pkg::*;
#(
   parameter int DIV_BITS  = UART_DIV_BITS,
   parameter int FRAC_BITS = UART_FRAC_BITS,
   parameter int OVS_BITS  = UART_OVS_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic [DIV_BITS-1:0]  i_div_int,
   input  logic [FRAC_BITS-1:0] i_div_frac,
   input  logic [OVS_BITS-1:0]  i_ovs,
   input  logic                 i_rxsync,
   output logic                 o_txtick,
   output logic                 o_txpulse,
   output logic                 o_rxtick,
   output logic                 o_rxpulse,
   output logic                 o_rxwin
);

   logic [DIV_BITS-1:0]  div_q, div_d;
   logic [FRAC_BITS-1:0] frac_q, frac_d;
   logic [OVS_BITS-1:0]  ovs_q, ovs_d;

   logic                 tx_tc, rx_tc;
   logic [OVS_BITS:0]    tx_k, rx_k;
   logic [OVS_BITS:0]    n_plus1, mid;

   logic txtick_q, txtick_d, txpulse_q, txpulse_d;
   logic rxtick_q, rxtick_d, rxpulse_q, rxpulse_d;
   logic rxwin_q, rxwin_d;

   // Shadow config is left unreset: it is reloaded on every disabled edge,
   // so the first enable after reset always sees the live configuration.
   always_comb begin
      div_d  = div_q;
      frac_d = frac_q;
      ovs_d  = ovs_q;
      if (!i_en) begin
         div_d  = i_div_int;
         frac_d = i_div_frac;
         ovs_d  = i_ovs;
      end
   end

   always_ff @(posedge i_clk) begin
      div_q  <= div_d;
      frac_q <= frac_d;
      ovs_q  <= ovs_d;
   end

   uart_baud_prescaler #(
      .DIV_BITS  (DIV_BITS),
      .FRAC_BITS (FRAC_BITS),
      .OVS_BITS  (OVS_BITS)
   ) u_tx (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .en_i   (i_en),
      .clr_i  (1'b0),
      .div_i  (div_q),
      .frac_i (frac_q),
      .ovs_i  (ovs_q),
      .tc_o   (tx_tc),
      .k_o    (tx_k)
   );

   uart_baud_prescaler #(
      .DIV_BITS  (DIV_BITS),
      .FRAC_BITS (FRAC_BITS),
      .OVS_BITS  (OVS_BITS)
   ) u_rx (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .en_i   (i_en),
      .clr_i  (i_rxsync),
      .div_i  (div_q),
      .frac_i (frac_q),
      .ovs_i  (ovs_q),
      .tc_o   (rx_tc),
      .k_o    (rx_k)
   );

   assign n_plus1 = {1'b0, ovs_q} + (OVS_BITS+1)'(1);
   assign mid     = (OVS_BITS+1)'(mid_idx(32'(ovs_q)));

   always_comb begin
      txtick_d  = tx_tc;
      txpulse_d = tx_tc && (tx_k == n_plus1);
      rxtick_d  = rx_tc;
      rxpulse_d = rx_tc && (rx_k == mid);
      rxwin_d   = rx_tc && ((rx_k == mid - (OVS_BITS+1)'(1)) ||
                            (rx_k == mid) ||
                            (rx_k == mid + (OVS_BITS+1)'(1)));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         txtick_q  <= 1'b0;
         txpulse_q <= 1'b0;
         rxtick_q  <= 1'b0;
         rxpulse_q <= 1'b0;
         rxwin_q   <= 1'b0;
      end else begin
         txtick_q  <= txtick_d;
         txpulse_q <= txpulse_d;
         rxtick_q  <= rxtick_d;
         rxpulse_q <= rxpulse_d;
         rxwin_q   <= rxwin_d;
      end
   end

   assign o_txtick  = txtick_q;
   assign o_txpulse = txpulse_q;
   assign o_rxtick  = rxtick_q;
   assign o_rxpulse = rxpulse_q;
   assign o_rxwin   = rxwin_q;

endmodule

// File: tb/tb_uart_baudgen.sv
// -----------------------------------------------------------------------------
// tb_uart_baudgen
// Directed bench for uart_baudgen. Edges are numbered from the last mark();
// every output pulse is logged with the edge number after which it is seen.
// Fractional expectations follow UART_BAUDGEN_FRAC_EN.
// -----------------------------------------------------------------------------
module tb_uart_baudgen;

   localparam int DIV_BITS  = 16;
   localparam int FRAC_BITS = 4;
   localparam int OVS_BITS  = 4;

   logic                 i_clk;
   logic                 i_rst;
   logic                 i_en;
   logic [DIV_BITS-1:0]  i_div_int;
   logic [FRAC_BITS-1:0] i_div_frac;
   logic [OVS_BITS-1:0]  i_ovs;
   logic                 i_rxsync;
   logic                 o_txtick;
   logic                 o_txpulse;
   logic                 o_rxtick;
   logic                 o_rxpulse;
   logic                 o_rxwin;

   int n_cmp = 0;
   int n_err = 0;
   int ecnt  = 0;
   int txt_q[$];
   int txp_q[$];
   int rxt_q[$];
   int rxp_q[$];
   int rxw_q[$];

   uart_baudgen #(
      .DIV_BITS  (DIV_BITS),
      .FRAC_BITS (FRAC_BITS),
      .OVS_BITS  (OVS_BITS)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_div_int  (i_div_int),
      .i_div_frac (i_div_frac),
      .i_ovs      (i_ovs),
      .i_rxsync   (i_rxsync),
      .o_txtick   (o_txtick),
      .o_txpulse  (o_txpulse),
      .o_rxtick   (o_rxtick),
      .o_rxpulse  (o_rxpulse),
      .o_rxwin    (o_rxwin)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   function automatic int outs();
      return 32'({o_txtick, o_txpulse, o_rxtick, o_rxpulse, o_rxwin});
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mark();
      ecnt = 0;
      txt_q.delete();
      txp_q.delete();
      rxt_q.delete();
      rxp_q.delete();
      rxw_q.delete();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge i_clk);
         #1;
         ecnt++;
         if (o_txtick)  txt_q.push_back(ecnt);
         if (o_txpulse) txp_q.push_back(ecnt);
         if (o_rxtick)  rxt_q.push_back(ecnt);
         if (o_rxpulse) rxp_q.push_back(ecnt);
         if (o_rxwin)   rxw_q.push_back(ecnt);
      end
   endtask

   initial begin
      i_rst      = 1'b1;
      i_en       = 1'b0;
      i_div_int  = 16'd3;
      i_div_frac = 4'd0;
      i_ovs      = 4'd15;
      i_rxsync   = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset_outputs", outs(), 0);
      i_rst = 1'b0;
      run(2);
      chk("disabled_idle", outs(), 0);

      // D=3, N=15, F=0 from a fresh enable
      i_en = 1'b1;
      mark();
      run(130);
      chk("tx_tick_1st",   qat(txt_q, 0), 4);
      chk("tx_tick_2nd",   qat(txt_q, 1), 8);
      chk("tx_tick_count", txt_q.size(), 32);
      chk("tx_pulse_1st",  qat(txp_q, 0), 64);
      chk("tx_pulse_2nd",  qat(txp_q, 1), 128);
      chk("tx_pulse_cnt",  txp_q.size(), 2);
      chk("rx_pulse_en",   qat(rxp_q, 0), 32);
      chk("rx_win_en",     qat(rxw_q, 0), 28);

      // RX resync at edge 1
      i_rxsync = 1'b1;
      mark();
      run(1);
      i_rxsync = 1'b0;
      run(99);
      chk("sync_rxtick_1st", qat(rxt_q, 0), 5);
      chk("sync_win_0",      qat(rxw_q, 0), 29);
      chk("sync_win_1",      qat(rxw_q, 1), 33);
      chk("sync_win_2",      qat(rxw_q, 2), 37);
      chk("sync_pulse_1st",  qat(rxp_q, 0), 33);
      chk("sync_pulse_2nd",  qat(rxp_q, 1), 97);
      chk("sync_pulse_cnt",  rxp_q.size(), 2);
      chk("sync_tx_cadence", qat(txt_q, 0), 2);

      // Resync landing on an RX terminal-count edge
      i_rxsync = 1'b1;
      mark();
      run(1);
      i_rxsync = 1'b0;
      chk("tc_sync_no_tick", rxt_q.size(), 0);
      run(8);
      chk("tc_sync_next",    qat(rxt_q, 0), 5);
      chk("tc_sync_count",   rxt_q.size(), 2);
      chk("tc_tx_tick_1st",  qat(txt_q, 0), 2);
      chk("tc_tx_tick_2nd",  qat(txt_q, 1), 6);

      // Disable mid-bit
      i_en = 1'b0;
      mark();
      run(1);
      chk("disable_outs", outs(), 0);
      run(5);
      chk("disable_events",
          txt_q.size() + txp_q.size() + rxt_q.size() + rxp_q.size() + rxw_q.size(), 0);

      // D=0, N=3; divider change while enabled must be ignored
      i_div_int = 16'd0;
      i_ovs     = 4'd3;
      run(1);
      i_en = 1'b1;
      mark();
      i_div_int = 16'd7;
      run(12);
      chk("d0_tick_count",  txt_q.size(), 12);
      chk("d0_pulse_1st",   qat(txp_q, 0), 4);
      chk("d0_pulse_count", txp_q.size(), 3);
      chk("d0_rxpulse_1st", qat(rxp_q, 0), 2);
      chk("d0_rxpulse_2nd", qat(rxp_q, 1), 6);
      i_rxsync = 1'b1;
      mark();
      run(1);
      i_rxsync = 1'b0;
      run(8);
      chk("d0_sync_rxtick", qat(rxt_q, 0), 2);
      chk("d0_sync_pulse",  qat(rxp_q, 0), 3);

      // Asynchronous reset mid-operation, then fresh enable
      i_en      = 1'b0;
      i_div_int = 16'd3;
      i_ovs     = 4'd15;
      run(2);
      i_en = 1'b1;
      mark();
      run(4);
      chk("pre_reset_outs", outs(), 20);
      #2;
      i_rst = 1'b1;
      #1;
      chk("async_reset_outs", outs(), 0);
      i_en = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      run(1);
      i_en = 1'b1;
      mark();
      run(70);
      chk("rst_tx_tick_1st",  qat(txt_q, 0), 4);
      chk("rst_tx_pulse_1st", qat(txp_q, 0), 64);
      chk("rst_rx_pulse_1st", qat(rxp_q, 0), 32);

      // D=2, F=8
      i_en       = 1'b0;
      i_div_int  = 16'd2;
      i_div_frac = 4'd8;
      run(1);
      i_en = 1'b1;
      mark();
      run(60);
`ifdef UART_BAUDGEN_FRAC_EN
      chk("frac_tick_1",  qat(txt_q, 0), 3);
      chk("frac_tick_2",  qat(txt_q, 1), 6);
      chk("frac_tick_3",  qat(txt_q, 2), 10);
      chk("frac_tick_4",  qat(txt_q, 3), 13);
      chk("frac_tick_16", qat(txt_q, 15), 55);
`else
      chk("nofrac_tick_1",  qat(txt_q, 0), 3);
      chk("nofrac_tick_3",  qat(txt_q, 2), 9);
      chk("nofrac_tick_16", qat(txt_q, 15), 48);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
